// File: rtl/grid_dbuf_if.sv
// Playfield store bus: renderer read port, game-logic edit port and bank/sequencer commands.
interface grid_dbuf_if #(
  parameter int CELL_BITS = 3,
  parameter int COORD_W   = 8
);
  logic [COORD_W-1:0]   rd_x, rd_y;
  logic [CELL_BITS-1:0] rd_data;
  logic                 rd_oob;
  logic                 wr_en;
  logic [COORD_W-1:0]   wr_x, wr_y;
  logic [CELL_BITS-1:0] wr_data;
  logic                 swap_req, frame_end;
  logic                 collapse_req;
  logic [COORD_W-1:0]   collapse_row;
  logic                 clear_req;
  logic                 busy, swap_done, cmd_err;

  modport master (
    output rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, swap_req, frame_end,
           collapse_req, collapse_row, clear_req,
    input  rd_data, rd_oob, busy, swap_done, cmd_err
  );
  modport slave (
    input  rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, swap_req, frame_end,
           collapse_req, collapse_row, clear_req,
    output rd_data, rd_oob, busy, swap_done, cmd_err
  );
endinterface

// File: rtl/grid_dbuf_ctrl.sv
// Double-buffered Tetris playfield: front bank read by the renderer, back bank edited by game logic,
// frame-synchronous swap followed by a row sequencer (copy/collapse/clear). Optional macro ROW_FULL_DETECT_EN.
module grid_dbuf_ctrl #(
  parameter int GRID_W    = 8,
  parameter int GRID_H    = 18,
  parameter int CELL_BITS = 3,
  parameter int COORD_W   = 8
) (
  input  logic      clk,
  input  logic      rst,
  grid_dbuf_if.slave bus
`ifdef ROW_FULL_DETECT_EN
  , output logic [GRID_H-1:0] row_full
`endif
);
  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [COORD_W-1:0] W_LIM = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(GRID_H);
  localparam logic [YW-1:0] LAST_ROW = YW'(GRID_H - 1);

  typedef enum logic [1:0] {IDLE, COPY, COLLAPSE, CLEAR} state_e;
  typedef logic [GRID_W-1:0][CELL_BITS-1:0] row_t;

  state_e               state_q, state_d;
  logic [YW-1:0]        row_cnt_q, row_cnt_d;
  logic                 front_sel_q, front_sel_d;
  logic                 pend_q, pend_d;
  logic                 swap_done_q, swap_done_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [CELL_BITS-1:0] rd_data_q;
  logic                 rd_oob_q;
  row_t [1:0][GRID_H-1:0] bank_q;

  logic bk, rd_in, wr_in;
  logic do_wr, do_copy, do_shift, do_zero;

  assign bk    = ~front_sel_q;
  assign rd_in = (bus.rd_x < W_LIM) && (bus.rd_y < H_LIM);
  assign wr_in = (bus.wr_x < W_LIM) && (bus.wr_y < H_LIM);

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_oob    = rd_oob_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.swap_done = swap_done_q;
  assign bus.cmd_err   = cmd_err_q;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    front_sel_d = front_sel_q;
    pend_d      = pend_q | bus.swap_req;
    swap_done_d = 1'b0;
    cmd_err_d   = 1'b0;
    do_wr       = 1'b0;
    do_copy     = 1'b0;
    do_shift    = 1'b0;
    do_zero     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((pend_q | bus.swap_req) && bus.frame_end) begin
          front_sel_d = ~front_sel_q;
          pend_d      = 1'b0;
          swap_done_d = 1'b1;
          row_cnt_d   = '0;
          state_d     = COPY;
          cmd_err_d   = bus.collapse_req | bus.clear_req | bus.wr_en;
        end else if (bus.collapse_req) begin
          if (bus.collapse_row < H_LIM) begin
            row_cnt_d = bus.collapse_row[YW-1:0];
            state_d   = COLLAPSE;
            cmd_err_d = bus.clear_req | bus.wr_en;
          end else begin
            cmd_err_d = 1'b1;
          end
        end else if (bus.clear_req) begin
          row_cnt_d = '0;
          state_d   = CLEAR;
          cmd_err_d = bus.wr_en;
        end else if (bus.wr_en) begin
          do_wr     = wr_in;
          cmd_err_d = ~wr_in;
        end
      end
      COPY: begin
        do_copy   = 1'b1;
        row_cnt_d = row_cnt_q + YW'(1);
        if (row_cnt_q == LAST_ROW) state_d = IDLE;
      end
      COLLAPSE: begin
        if (row_cnt_q != '0) begin
          do_shift  = 1'b1;
          row_cnt_d = row_cnt_q - YW'(1);
        end else begin
          do_zero = 1'b1;
          state_d = IDLE;
        end
      end
      CLEAR: begin
        do_zero   = 1'b1;
        row_cnt_d = row_cnt_q + YW'(1);
        if (row_cnt_q == LAST_ROW) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The sequencer owns the back bank; edits arriving meanwhile are refused.
    if (state_q != IDLE && (bus.wr_en || bus.collapse_req || bus.clear_req))
      cmd_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      front_sel_q <= 1'b0;
      pend_q      <= 1'b0;
      swap_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      front_sel_q <= front_sel_d;
      pend_q      <= pend_d;
      swap_done_q <= swap_done_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Uses front_sel_q, so a read on the commit edge still sees the outgoing front.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_oob_q  <= 1'b0;
    end else if (rd_in) begin
      rd_data_q <= bank_q[front_sel_q][bus.rd_y[YW-1:0]][bus.rd_x[XW-1:0]];
      rd_oob_q  <= 1'b0;
    end else begin
      rd_data_q <= '0;
      rd_oob_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
    end else begin
      if (do_wr)    bank_q[bk][bus.wr_y[YW-1:0]][bus.wr_x[XW-1:0]] <= bus.wr_data;
      if (do_copy)  bank_q[bk][row_cnt_q] <= bank_q[front_sel_q][row_cnt_q];
      if (do_shift) bank_q[bk][row_cnt_q] <= bank_q[bk][row_cnt_q - YW'(1)];
      if (do_zero)  bank_q[bk][row_cnt_q] <= '0;
    end
  end

`ifdef ROW_FULL_DETECT_EN
  logic [GRID_H-1:0] full_d;

  always_comb begin
    full_d = '1;
    for (int r = 0; r < GRID_H; r++)
      for (int c = 0; c < GRID_W; c++)
        if (bank_q[bk][r][c] == '0) full_d[r] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) row_full <= '0;
    else     row_full <= full_d;
  end
`endif
endmodule

// File: doc/grid_dbuf_ctrl.md
Name: grid_dbuf_ctrl

Overview:
- Parametrised double-buffered playfield store for the Tetris display path.
- Game logic edits a back bank one cell at a time. The VGA renderer reads a front bank with one-cycle latency.
- A swap, requested by game logic and committed only at the frame boundary, exchanges the banks.
- A sequencer then copies the new front into the back bank, and provides row-collapse and clear operations.

Parameters:
- GRID_W, 8, cells per row
- GRID_H, 18, rows (row 0 = top)
- CELL_BITS, 3, bits per cell (0 = empty, nonzero = colour code)
- COORD_W, 8, width of x/y coordinate inputs

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rd_x  in  COORD_W  front-bank read column
- rd_y  in  COORD_W  front-bank read row
- rd_data  out  CELL_BITS  registered cell value
- rd_oob  out  1  registered: last read was out of range
- wr_en  in  1  back-bank cell write strobe
- wr_x  in  COORD_W  write column
- wr_y  in  COORD_W  write row
- wr_data  in  CELL_BITS  write value
- swap_req  in  1  pulse: request bank swap
- frame_end  in  1  pulse from renderer: frame drawn, swap may commit
- collapse_req  in  1  pulse: delete back-bank row collapse_row, shift rows above down
- collapse_row  in  COORD_W  row to delete
- clear_req  in  1  pulse: zero the back bank
- busy  out  1  sequencer active (COPY/COLLAPSE/CLEAR)
- swap_done  out  1  one-cycle pulse on swap commit
- cmd_err  out  1  one-cycle pulse: a command or write was dropped

Behaviour:
- Reset (async, any state): both banks zero; front_sel=0; swap_pending=0; state IDLE. Outputs rd_data=0, rd_oob=0, busy=0, swap_done=0, cmd_err=0. Reset mid-operation abandons it with no partial effects kept.
- Read (every cycle, any state): at the edge, rd_data <= front[rd_y][rd_x] and rd_oob <= 0 when rd_x<GRID_W and rd_y<GRID_H. Otherwise rd_data <= 0 and rd_oob <= 1.
  - Latency is 1 cycle.
  - On a swap-commit edge, the read returns the old front.
- swap_req in any state sets swap_pending. A repeat while pending is absorbed, with no error.
- States:
  - IDLE:
    - Priority 1, swap commit: when (swap_pending or swap_req) and frame_end. Toggle front_sel, clear swap_pending, pulse swap_done, row_cnt=0, go to COPY.
    - Priority 2, collapse_req: collapse_row<GRID_H gives row_cnt=collapse_row and goes to COLLAPSE. Otherwise pulse cmd_err.
    - Priority 3, clear_req: row_cnt=0, go to CLEAR.
    - Priority 4, wr_en: write back[wr_y][wr_x]<=wr_data if in range, else pulse cmd_err.
    - Lower-priority same-cycle commands are dropped with a cmd_err pulse, except a swap_req that is still latched.
  - COPY: back[row_cnt] <= front[row_cnt]; row_cnt++. After row GRID_H-1, go to IDLE. Takes exactly GRID_H cycles.
  - COLLAPSE: row_cnt>0 gives back[row_cnt] <= back[row_cnt-1] and row_cnt--. row_cnt==0 gives back[0] <= 0 and goes to IDLE. Takes collapse_row+1 cycles.
  - CLEAR: back[row_cnt] <= 0; row_cnt++. After GRID_H-1, go to IDLE. Takes GRID_H cycles.
- busy=1 in COPY, COLLAPSE and CLEAR, registered with the state.
- While busy, wr_en, collapse_req and clear_req are dropped with a cmd_err pulse. swap_req still latches. frame_end while busy does not commit; the commit waits for a later frame_end in IDLE.
- row_cnt is $clog2(GRID_H) bits wide. Coordinates are compared at full COORD_W width, so there is no truncation aliasing.
- Front bank is never written except through bank selection.

Optional Feature:
- Macro ROW_FULL_DETECT_EN adds output row_full[GRID_H-1:0], registered.
  - Bit r=1 when every cell of back row r is nonzero. Updated every cycle; reset 0.
  - Without the macro: no port and no logic.

Test Plan:
- Reset then read (3,5) -> rd_data=0, rd_oob=0 next cycle; read (8,0) -> rd_data=0, rd_oob=1.
- Write (2,4)=5, swap_req, frame_end 10 cycles later:
  - swap_done pulses on the commit edge; busy is high 18 cycles.
  - Reading (2,4) gives 5.
  - A read issued on the commit edge gives 0.
- Write (0,16)=1 and (0,17)=2, collapse_row=17, swap+frame_end -> front (0,17)=1, (0,16)=0; busy for 18 cycles during collapse.
- wr_en during COPY -> cmd_err pulse, back bank unchanged; swap_req during COPY with frame_end mid-COPY -> no commit until next frame_end after busy falls.
- collapse_row=18 -> cmd_err pulse, no state change; clear_req then swap -> whole front reads 0.
- Assert rst in the middle of COLLAPSE -> busy=0 immediately, all cells read 0, pending swap lost.
